mem_access: RTL and testbench

//  Data-memory stage directly downstream of the ALU. Takes load/store opcode, effective address and rt store

---
 rtl/mem_access_pkg.sv | 63 ++++++
 rtl/mem_access_load_extract.sv | 40 ++++
 rtl/mem_access.sv | 129 ++++++++++++
 tb/tb_mem_access.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared codes for the data-memory stage: opcodes, word type, FSM states and
// small decode helpers used by both the request side and the load extractor.
// No logic state lives here; everything is pure types and functions.
package mem_access_pkg;

  localparam int unsigned WORD_W = 32;

  // Data and address width of the stage.
  typedef logic [WORD_W-1:0] size_t;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_ADDI    = 6'h08,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_REQ   = 2'd1,
    MEM_RDATA = 2'd2
  } mem_state_t;

  function automatic logic is_load_op(input opcode_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store_op(input opcode_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Words need both low address bits clear, halves only bit 0.
  function automatic logic is_misaligned(input opcode_t op, input logic [1:0] k);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (k != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = k[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Loads and stores of the same size touch the same lanes.
  function automatic logic [3:0] lane_enable(input opcode_t op, input logic [1:0] k);
    logic [3:0] be;
    be = 4'b1111;
    case (op)
      OP_LB, OP_LBU, OP_SB: be = 4'b0001 << k;
      OP_LH, OP_LHU, OP_SH: be = k[1] ? 4'b1100 : 4'b0011;
      default:              be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Purpose: picks the addressed byte/half out of a read word and sign/zero extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is sampled.
// Ports: opcode (load kind), ea_lo (address bits [1:0]), readdata (raw bus word),
//        load_data (extended 32-bit result).
module mem_load_extract
  import mem_access_pkg::*;
(
  input  opcode_t     opcode,
  input  logic [1:0]  ea_lo,
  input  size_t       readdata,
  output size_t       load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readdata[7:0];
    case (ea_lo)
      2'd0:    byte_sel = readdata[7:0];
      2'd1:    byte_sel = readdata[15:8];
      2'd2:    byte_sel = readdata[23:16];
      default: byte_sel = readdata[31:24];
    endcase
    half_sel = ea_lo[1] ? readdata[31:16] : readdata[15:0];
  end

  always_comb begin
    load_data = readdata;
    case (opcode)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Purpose: data-memory stage; one Avalon-MM style load/store per start, with lane steering and load extension.
// Latency: store 2 cycles start->done, load 3 cycles, misaligned 1 cycle; +1 per waitrequest cycle.
// Backpressure: request held stable while waitrequest_i is high; start_i ignored unless idle.
// Ports: clk/reset (async active-high); start_i, opcode_i, effective_address_i, store_data_i from the ALU;
//        address_o, read_o, write_o, byteenable_o, writedata_o, waitrequest_i, readdata_i on the bus;
//        load_data_o, done_o, addr_error_o, busy_o back to the pipeline.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        addr_error_o,
  output logic        busy_o
);

  mem_state_t state_q, state_d;
  opcode_t    op_in, op_q;
  logic [1:0] k_q;
  size_t      address_q, wdata_q, wdata_d, load_data_q, extracted;
  logic [3:0] be_q;
  logic       done_q, err_q;
  logic       mem_start, accept, reject;

  assign op_in     = opcode_t'(opcode_i);
  assign mem_start = (state_q == MEM_IDLE) && start_i &&
                     (is_load_op(op_in) || is_store_op(op_in));
  assign accept    = mem_start && !is_misaligned(op_in, effective_address_i[1:0]);
  assign reject    = mem_start &&  is_misaligned(op_in, effective_address_i[1:0]);

  // Store data is replicated into every lane; byteenable picks the live ones.
  always_comb begin
    wdata_d = store_data_i;
    case (op_in)
      OP_SB:   wdata_d = {4{store_data_i[7:0]}};
      OP_SH:   wdata_d = {2{store_data_i[15:0]}};
      default: wdata_d = store_data_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE:  if (accept) state_d = MEM_REQ;
      MEM_REQ:   if (!waitrequest_i) state_d = is_load_op(op_q) ? MEM_RDATA : MEM_IDLE;
      MEM_RDATA: state_d = MEM_IDLE;
      default:   state_d = MEM_IDLE;
    endcase
  end

  // FSM outputs; decoded from state so reset drops the request at once.
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    busy_o  = (state_q != MEM_IDLE);
    if (state_q == MEM_REQ) begin
      read_o  = is_load_op(op_q);
      write_o = is_store_op(op_q);
    end
  end

  mem_load_extract u_extract (
    .opcode    (op_q),
    .ea_lo     (k_q),
    .readdata  (readdata_i),
    .load_data (extracted)
  );

  // Request registers and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_SPECIAL;
      k_q         <= 2'b00;
      address_q   <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        op_q      <= op_in;
        k_q       <= effective_address_i[1:0];
        address_q <= {effective_address_i[31:2], 2'b00};
        be_q      <= lane_enable(op_in, effective_address_i[1:0]);
        wdata_q   <= wdata_d;
      end
      if (reject) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if ((state_q == MEM_REQ) && !waitrequest_i && is_store_op(op_q))
        done_q <= 1'b1;
      if (state_q == MEM_RDATA) begin
        load_data_q <= extracted;
        done_q      <= 1'b1;
      end
    end
  end

  assign address_o    = address_q;
  assign byteenable_o = be_q;
  assign writedata_o  = wdata_q;
  assign load_data_o  = load_data_q;
  assign done_o       = done_q;
  assign addr_error_o = err_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [5:0] C_LB = 6'h20, C_LH = 6'h21, C_LW = 6'h23, C_LBU = 6'h24,
                         C_LHU = 6'h25, C_SB = 6'h28, C_SH = 6'h29, C_SW = 6'h2B,
                         C_ADDI = 6'h08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  opcode_i = 6'h0;
  logic [31:0] effective_address_i = '0;
  logic [31:0] store_data_i = '0;
  logic [31:0] address_o;
  logic        read_o, write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic        waitrequest_i = 1'b0;
  logic [31:0] readdata_i = '0;
  logic [31:0] load_data_o;
  logic        done_o, addr_error_o, busy_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .address_o           (address_o),
    .read_o              (read_o),
    .write_o             (write_o),
    .byteenable_o        (byteenable_o),
    .writedata_o         (writedata_o),
    .waitrequest_i       (waitrequest_i),
    .readdata_i          (readdata_i),
    .load_data_o         (load_data_o),
    .done_o              (done_o),
    .addr_error_o        (addr_error_o),
    .busy_o              (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start (caller is 1ns after an edge) and watches 12 cycles.
  // Cycle numbers count edges after the start was presented.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] rt,
                         input logic [31:0] rdata, input int nwait,
                         output int done_at, output int done_cnt, output int err_cnt,
                         output int rd_n, output int wr_n, output logic [3:0] be_f,
                         output logic [31:0] addr_f, output logic [31:0] wd_f,
                         output logic stable, output logic [31:0] ld);
    int req_n;
    done_at = -1; done_cnt = 0; err_cnt = 0; rd_n = 0; wr_n = 0; req_n = 0;
    be_f = '0; addr_f = '0; wd_f = '0; stable = 1'b1; ld = '0;
    opcode_i = op; effective_address_i = ea; store_data_i = rt; readdata_i = rdata;
    waitrequest_i = 1'b0; start_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start_i = 1'b0;
      if (read_o || write_o) begin
        if (req_n == 0) begin
          be_f = byteenable_o; addr_f = address_o; wd_f = writedata_o;
        end else if (byteenable_o !== be_f || address_o !== addr_f || writedata_o !== wd_f) begin
          stable = 1'b0;
        end
        if (read_o) rd_n++;
        if (write_o) wr_n++;
        waitrequest_i = (req_n < nwait);
        req_n++;
      end else begin
        waitrequest_i = 1'b0;
      end
      if (done_o) begin
        if (done_cnt == 0) begin
          done_at = c;
          ld = load_data_o;
        end
        done_cnt++;
      end
      if (addr_error_o) err_cnt++;
    end
  endtask

  task automatic test_reset();
    tick();
    total++; if ({read_o, write_o, done_o, addr_error_o, busy_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {read_o, write_o, done_o, addr_error_o, busy_o});
    end
    total++; if ({address_o, byteenable_o, writedata_o, load_data_o} !== 100'h0) begin
      bad++; $display("FAIL reset_data addr=%h be=%b wd=%h ld=%h exp all zero",
                      address_o, byteenable_o, writedata_o, load_data_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    int da, dc, ec, rn, wn; logic [3:0] be; logic [31:0] a, wd, ld; logic st;
    run_txn(C_LW, 32'h1000, 32'h0, 32'hDEADBEEF, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (rn !== 1 || wn !== 0) begin bad++; $display("FAIL lw_bus rd=%0d wr=%0d exp 1/0", rn, wn); end
    total++; if (a !== 32'h1000 || be !== 4'b1111) begin bad++; $display("FAIL lw_req addr=%h be=%b exp 00001000/1111", a, be); end
    total++; if (da !== 3 || dc !== 1) begin bad++; $display("FAIL lw_done at=%0d cnt=%0d exp 3/1", da, dc); end
    total++; if (ld !== 32'hDEADBEEF || ec !== 0) begin bad++; $display("FAIL lw_data got=%h err=%0d exp deadbeef/0", ld, ec); end
  endtask

  task automatic test_byte_half_loads();
    int da, dc, ec, rn, wn; logic [3:0] be; logic [31:0] a, wd, ld; logic st;
    run_txn(C_LB, 32'h1003, 32'h0, 32'h80FF0000, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (ld !== 32'hFFFFFF80 || be !== 4'b1000 || a !== 32'h1000) begin
      bad++; $display("FAIL lb got=%h be=%b addr=%h exp ffffff80/1000/00001000", ld, be, a); end
    run_txn(C_LBU, 32'h1003, 32'h0, 32'h80FF0000, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (ld !== 32'h00000080 || be !== 4'b1000) begin
      bad++; $display("FAIL lbu got=%h be=%b exp 00000080/1000", ld, be); end
    run_txn(C_LH, 32'h1002, 32'h0, 32'h8001_7FFF, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (ld !== 32'hFFFF8001 || be !== 4'b1100) begin
      bad++; $display("FAIL lh got=%h be=%b exp ffff8001/1100", ld, be); end
    run_txn(C_LHU, 32'h1000, 32'h0, 32'h1234_9ABC, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (ld !== 32'h00009ABC || be !== 4'b0011) begin
      bad++; $display("FAIL lhu got=%h be=%b exp 00009abc/0011", ld, be); end
  endtask

  task automatic test_stores();
    int da, dc, ec, rn, wn; logic [3:0] be; logic [31:0] a, wd, ld; logic st;
    run_txn(C_SH, 32'h2002, 32'h1234ABCD, 32'h0, 3, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (wn !== 4 || rn !== 0 || !st) begin bad++; $display("FAIL sh_wait wr=%0d rd=%0d stable=%b exp 4/0/1", wn, rn, st); end
    total++; if (wd !== 32'hABCDABCD || be !== 4'b1100 || a !== 32'h2000) begin
      bad++; $display("FAIL sh_lanes wd=%h be=%b addr=%h exp abcdabcd/1100/00002000", wd, be, a); end
    total++; if (da !== 5 || dc !== 1) begin bad++; $display("FAIL sh_done at=%0d cnt=%0d exp 5/1", da, dc); end
    run_txn(C_SB, 32'h7001, 32'h0000125A, 32'h0, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (wd !== 32'h5A5A5A5A || be !== 4'b0010 || da !== 2 || wn !== 1) begin
      bad++; $display("FAIL sb wd=%h be=%b at=%0d wr=%0d exp 5a5a5a5a/0010/2/1", wd, be, da, wn); end
    run_txn(C_SW, 32'h7008, 32'hCAFEF00D, 32'h0, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (wd !== 32'hCAFEF00D || be !== 4'b1111 || a !== 32'h7008 || da !== 2) begin
      bad++; $display("FAIL sw wd=%h be=%b addr=%h at=%0d exp cafef00d/1111/00007008/2", wd, be, a, da); end
  endtask

  task automatic test_misaligned();
    int da, dc, ec, rn, wn; logic [3:0] be; logic [31:0] a, wd, ld; logic st;
    run_txn(C_LW, 32'h1001, 32'h0, 32'h0, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (rn !== 0 || wn !== 0) begin bad++; $display("FAIL lw_mis_bus rd=%0d wr=%0d exp 0/0", rn, wn); end
    total++; if (da !== 1 || dc !== 1 || ec !== 1) begin
      bad++; $display("FAIL lw_mis_done at=%0d cnt=%0d err=%0d exp 1/1/1", da, dc, ec); end
    run_txn(C_SH, 32'h2003, 32'h0, 32'h0, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (wn !== 0 || da !== 1 || ec !== 1) begin
      bad++; $display("FAIL sh_mis wr=%0d at=%0d err=%0d exp 0/1/1", wn, da, ec); end
  endtask

  task automatic test_reset_mid();
    int da, dc, ec, rn, wn; logic [3:0] be; logic [31:0] a, wd, ld; logic st;
    int seen_done, seen_rd;
    opcode_i = C_LW; effective_address_i = 32'h3000; waitrequest_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++; if (read_o !== 1'b1) begin bad++; $display("FAIL rst_pre read=%b exp 1", read_o); end
    #2 reset = 1'b1;
    #1;
    total++; if (read_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rst_async read=%b busy=%b exp 0/0", read_o, busy_o); end
    waitrequest_i = 1'b0;
    tick();
    reset = 1'b0;
    seen_done = 0; seen_rd = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done_o) seen_done++;
      if (read_o) seen_rd++;
    end
    total++; if (seen_done !== 0 || seen_rd !== 0) begin
      bad++; $display("FAIL rst_quiet done=%0d read=%0d exp 0/0", seen_done, seen_rd); end
    run_txn(C_LHU, 32'h4000, 32'h0, 32'h0000F00D, 0, da, dc, ec, rn, wn, be, a, wd, st, ld);
    total++; if (ld !== 32'h0000F00D || da !== 3 || be !== 4'b0011) begin
      bad++; $display("FAIL rst_lhu got=%h at=%0d be=%b exp 0000f00d/3/0011", ld, da, be); end
  endtask

  task automatic test_ignored_starts();
    int req_n, dn, d_at, wn, rn;
    req_n = 0; dn = 0; d_at = -1; wn = 0; rn = 0;
    opcode_i = C_SW; effective_address_i = 32'h5000; store_data_i = 32'h11223344; start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      if (c == 1 || c == 2) begin
        start_i = 1'b1; opcode_i = C_LB; effective_address_i = 32'h5100;
      end else if (c == 6) begin
        start_i = 1'b1; opcode_i = C_ADDI; effective_address_i = 32'h0;
      end
      if (read_o || write_o) begin
        waitrequest_i = (req_n < 2);
        req_n++;
        if (write_o) wn++;
        if (read_o) rn++;
      end else begin
        waitrequest_i = 1'b0;
      end
      if (done_o) begin dn++; if (d_at < 0) d_at = c; end
    end
    start_i = 1'b0;
    total++; if (dn !== 1 || d_at !== 4) begin bad++; $display("FAIL ignore_done cnt=%0d at=%0d exp 1/4", dn, d_at); end
    total++; if (wn !== 3 || rn !== 0) begin bad++; $display("FAIL ignore_bus wr=%0d rd=%0d exp 3/0", wn, rn); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, dn; logic [31:0] ld2, raddr; logic [3:0] rbe;
    d1 = -1; d2 = -1; dn = 0; ld2 = '0; raddr = '0; rbe = '0;
    waitrequest_i = 1'b0;
    opcode_i = C_SW; effective_address_i = 32'h6004; store_data_i = 32'hCAFEF00D; start_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start_i = 1'b0;
      if (read_o) begin raddr = address_o; rbe = byteenable_o; end
      if (done_o) begin
        dn++;
        if (d1 < 0) d1 = c; else begin d2 = c; ld2 = load_data_o; end
      end
      if (c == 2) begin
        start_i = 1'b1; opcode_i = C_LB; effective_address_i = 32'h6001; readdata_i = 32'h0000AB00;
      end
    end
    total++; if (d1 !== 2 || d2 !== 5 || dn !== 2) begin
      bad++; $display("FAIL b2b_done d1=%0d d2=%0d cnt=%0d exp 2/5/2", d1, d2, dn); end
    total++; if (ld2 !== 32'hFFFFFFAB || raddr !== 32'h6000 || rbe !== 4'b0010) begin
      bad++; $display("FAIL b2b_load got=%h addr=%h be=%b exp ffffffab/00006000/0010", ld2, raddr, rbe); end
  endtask

  initial begin
    fork
      begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not complete");
      end
    join_none
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_misaligned();
    test_reset_mid();
    test_ignored_starts();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
